// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline control unit: opcodes, functs, ALU and
// output-select codes, next-PC selects, the internal control record and bundle layouts.
package pipe_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_NOOP  = 6'b000000;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_XNOR  = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  localparam logic [3:0] ALU_NONE = 4'b0000;
  localparam logic [3:0] ALU_LUI  = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0100;
  localparam logic [3:0] ALU_ADDU = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SUBU = 4'b0111;
  localparam logic [3:0] ALU_AND  = 4'b1000;
  localparam logic [3:0] ALU_OR   = 4'b1001;
  localparam logic [3:0] ALU_XOR  = 4'b1010;
  localparam logic [3:0] ALU_XNOR = 4'b1011;
  localparam logic [3:0] ALU_SLT  = 4'b1100;
  localparam logic [3:0] ALU_SLTU = 4'b1101;

  localparam logic [1:0] OUT_ALU = 2'b00;
  localparam logic [1:0] OUT_HI  = 2'b01;
  localparam logic [1:0] OUT_LO  = 2'b10;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_JUMP   = 2'b01;
  localparam logic [1:0] PC_BRANCH = 2'b10;

  localparam int EX_ALU_SRC_BIT    = 11;
  localparam int EX_ALU_FUNC_MSB   = 10;
  localparam int EX_ALU_FUNC_LSB   = 7;
  localparam int EX_SE_ZE_BIT      = 6;
  localparam int EX_REG_DST_BIT    = 5;
  localparam int EX_START_MULT_BIT = 4;
  localparam int EX_MULT_SIGN_BIT  = 3;
  localparam int EX_OUT_SEL_MSB    = 2;
  localparam int EX_OUT_SEL_LSB    = 1;
  localparam int EX_VALID_BIT      = 0;

  localparam int MEM_WRITE_BIT = 2;
  localparam int MEM_READ_BIT  = 1;
  localparam int MEM_VALID_BIT = 0;

  localparam int WB_REG_WRITE_BIT  = 2;
  localparam int WB_MEM_TO_REG_BIT = 1;
  localparam int WB_VALID_BIT      = 0;

  // Full control record carried down the pipe; each stage exposes its slice.
  typedef struct packed {
    logic       alu_src;
    logic [3:0] alu_func;
    logic       se_ze;
    logic       reg_dst;
    logic       start_mult;
    logic       mult_sign;
    logic [1:0] out_sel;
    logic       mem_write;
    logic       mem_read;
    logic       reg_write;
    logic       mem_to_reg;
    logic       valid;
  } ctrl_t;

  function automatic logic [11:0] to_ex_bundle(input ctrl_t c);
    logic [11:0] b;
    b = '0;
    b[EX_ALU_SRC_BIT]                   = c.alu_src;
    b[EX_ALU_FUNC_MSB:EX_ALU_FUNC_LSB]  = c.alu_func;
    b[EX_SE_ZE_BIT]                     = c.se_ze;
    b[EX_REG_DST_BIT]                   = c.reg_dst;
    b[EX_START_MULT_BIT]                = c.start_mult;
    b[EX_MULT_SIGN_BIT]                 = c.mult_sign;
    b[EX_OUT_SEL_MSB:EX_OUT_SEL_LSB]    = c.out_sel;
    b[EX_VALID_BIT]                     = c.valid;
    return b;
  endfunction

  function automatic logic [2:0] to_mem_bundle(input ctrl_t c);
    logic [2:0] b;
    b = '0;
    b[MEM_WRITE_BIT] = c.mem_write;
    b[MEM_READ_BIT]  = c.mem_read;
    b[MEM_VALID_BIT] = c.valid;
    return b;
  endfunction

  function automatic logic [2:0] to_wb_bundle(input ctrl_t c);
    logic [2:0] b;
    b = '0;
    b[WB_REG_WRITE_BIT]  = c.reg_write;
    b[WB_MEM_TO_REG_BIT] = c.mem_to_reg;
    b[WB_VALID_BIT]      = c.valid;
    return b;
  endfunction

endpackage

// File: rtl/pipe_ctrl_unit_decode.sv
// Combinational ID-stage decoder: opcode/funct to control record plus the
// branch, jump and multiplier-dependency flags used by the hazard logic.
module ctrl_decode
  import pipe_ctrl_pkg::*;
(
  input  logic [5:0] op_code,
  input  logic [5:0] funct,
  output ctrl_t      ctrl,
  output logic       is_jump,
  output logic       is_beq,
  output logic       is_bne,
  output logic       is_mult_dep
);

  logic r_alu;
  logic imm_sext;
  logic imm_zext;

  always_comb begin
    ctrl        = '0;
    ctrl.valid  = 1'b1;
    is_jump     = 1'b0;
    is_beq      = 1'b0;
    is_bne      = 1'b0;
    is_mult_dep = 1'b0;
    r_alu       = 1'b0;
    imm_sext    = 1'b0;
    imm_zext    = 1'b0;

    case (op_code)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  begin r_alu = 1'b1; ctrl.alu_func = ALU_ADD;  end
          FN_ADDU: begin r_alu = 1'b1; ctrl.alu_func = ALU_ADDU; end
          FN_SUB:  begin r_alu = 1'b1; ctrl.alu_func = ALU_SUB;  end
          FN_SUBU: begin r_alu = 1'b1; ctrl.alu_func = ALU_SUBU; end
          FN_AND:  begin r_alu = 1'b1; ctrl.alu_func = ALU_AND;  end
          FN_OR:   begin r_alu = 1'b1; ctrl.alu_func = ALU_OR;   end
          FN_XOR:  begin r_alu = 1'b1; ctrl.alu_func = ALU_XOR;  end
          FN_XNOR: begin r_alu = 1'b1; ctrl.alu_func = ALU_XNOR; end
          FN_SLT:  begin r_alu = 1'b1; ctrl.alu_func = ALU_SLT;  end
          FN_SLTU: begin r_alu = 1'b1; ctrl.alu_func = ALU_SLTU; end
          FN_MFHI: begin
            ctrl.reg_dst   = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.out_sel   = OUT_HI;
            is_mult_dep    = 1'b1;
          end
          FN_MFLO: begin
            ctrl.reg_dst   = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.out_sel   = OUT_LO;
            is_mult_dep    = 1'b1;
          end
          FN_MULT: begin
            ctrl.start_mult = 1'b1;
            ctrl.mult_sign  = 1'b1;
            is_mult_dep     = 1'b1;
          end
          FN_MULTU: begin
            ctrl.start_mult = 1'b1;
            is_mult_dep     = 1'b1;
          end
          default: ;
        endcase
      end
      OP_J:     is_jump = 1'b1;
      OP_BEQ:   is_beq  = 1'b1;
      OP_BNE:   is_bne  = 1'b1;
      OP_ADDI:  begin imm_sext = 1'b1; ctrl.alu_func = ALU_ADD;  end
      OP_ADDIU: begin imm_sext = 1'b1; ctrl.alu_func = ALU_ADDU; end
      OP_SLTI:  begin imm_sext = 1'b1; ctrl.alu_func = ALU_SLT;  end
      OP_SLTIU: begin imm_sext = 1'b1; ctrl.alu_func = ALU_SLTU; end
      OP_ANDI:  begin imm_zext = 1'b1; ctrl.alu_func = ALU_AND;  end
      OP_ORI:   begin imm_zext = 1'b1; ctrl.alu_func = ALU_OR;   end
      OP_XORI:  begin imm_zext = 1'b1; ctrl.alu_func = ALU_XOR;  end
      OP_LUI:   begin imm_zext = 1'b1; ctrl.alu_func = ALU_LUI;  end
      OP_LW: begin
        ctrl.alu_src    = 1'b1;
        ctrl.se_ze      = 1'b1;
        ctrl.alu_func   = ALU_ADD;
        ctrl.mem_read   = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.se_ze     = 1'b1;
        ctrl.alu_func  = ALU_ADD;
        ctrl.mem_write = 1'b1;
      end
      default: ;
    endcase

    if (r_alu) begin
      ctrl.reg_dst   = 1'b1;
      ctrl.reg_write = 1'b1;
    end
    // Immediate forms write rt; only the extension mode differs.
    if (imm_sext || imm_zext) begin
      ctrl.alu_src   = 1'b1;
      ctrl.se_ze     = imm_sext;
      ctrl.reg_write = 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control: ID decode, EX/MEM/WB control registers, multiplier
// busy counter and the HI/LO interlock that stalls ID.
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_LATENCY  = 4,
  parameter int NUM_WB_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [5:0]  op_code,
  input  logic [5:0]  control_unit_funct,
  input  logic        eq_ne,
  output logic        id_stall,
  output logic [1:0]  pc_source,
  output logic        if_flush,
  output logic [11:0] ex_bundle,
  output logic [2:0]  mem_bundle,
  output logic [2:0]  wb_bundle,
  output logic        mult_busy
);

  ctrl_t      dec_ctrl;
  ctrl_t      ex_next;
  ctrl_t      ex_q;
  ctrl_t      stage_q [NUM_WB_STAGES];
  logic [3:0] busy_cnt_q;
  logic       is_jump;
  logic       is_beq;
  logic       is_bne;
  logic       is_mult_dep;
  logic       issue_ok;
  logic       br_taken;

  ctrl_decode u_decode (
    .op_code     (op_code),
    .funct       (control_unit_funct),
    .ctrl        (dec_ctrl),
    .is_jump     (is_jump),
    .is_beq      (is_beq),
    .is_bne      (is_bne),
    .is_mult_dep (is_mult_dep)
  );

  assign mult_busy = (busy_cnt_q != 4'd0);
  // rst_n gating keeps the combinational outputs quiet during reset.
  assign id_stall  = rst_n & id_valid & is_mult_dep & mult_busy;
  assign if_flush  = (pc_source != PC_SEQ);

  always_comb begin
    pc_source = PC_SEQ;
    ex_next   = '0;
    issue_ok  = rst_n & id_valid & ~id_stall;
    br_taken  = (is_beq & eq_ne) | (is_bne & ~eq_ne);
    if (issue_ok) begin
      ex_next = dec_ctrl;
      if (is_jump) begin
        pc_source = PC_JUMP;
      end else if (br_taken) begin
        pc_source = PC_BRANCH;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q       <= '0;
      busy_cnt_q <= '0;
      for (int i = 0; i < NUM_WB_STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      ex_q       <= ex_next;
      stage_q[0] <= ex_q;
      for (int i = 1; i < NUM_WB_STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
      // A new multiply can only issue when idle, since it interlocks on busy.
      if (ex_next.start_mult) begin
        busy_cnt_q <= 4'(MULT_LATENCY);
      end else if (mult_busy) begin
        busy_cnt_q <= busy_cnt_q - 4'd1;
      end
    end
  end

  assign ex_bundle  = to_ex_bundle(ex_q);
  assign mem_bundle = to_mem_bundle(stage_q[0]);
  assign wb_bundle  = to_wb_bundle(stage_q[NUM_WB_STAGES-1]);

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: directed scenarios followed by
// random instruction streams, compared against a history-based reference model.
module tb_pipe_ctrl_unit;

  localparam int L   = 4;
  localparam int NWB = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [5:0]  op_code = '0;
  logic [5:0]  control_unit_funct = '0;
  logic        eq_ne = 1'b0;
  logic        id_stall;
  logic [1:0]  pc_source;
  logic        if_flush;
  logic [11:0] ex_bundle;
  logic [2:0]  mem_bundle;
  logic [2:0]  wb_bundle;
  logic        mult_busy;

  always #5 clk = ~clk;

  pipe_ctrl_unit #(.MULT_LATENCY(L), .NUM_WB_STAGES(NWB)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .id_valid           (id_valid),
    .op_code            (op_code),
    .control_unit_funct (control_unit_funct),
    .eq_ne              (eq_ne),
    .id_stall           (id_stall),
    .pc_source          (pc_source),
    .if_flush           (if_flush),
    .ex_bundle          (ex_bundle),
    .mem_bundle         (mem_bundle),
    .wb_bundle          (wb_bundle),
    .mult_busy          (mult_busy)
  );

  typedef enum int {C_NOP, C_RALU, C_IALU_S, C_IALU_Z, C_LOAD, C_STORE,
                    C_BEQ, C_BNE, C_JMP, C_MFHI, C_MFLO, C_MULT, C_MULTU} cat_e;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    cat_e       cat;
    logic [3:0] alu;
  } instr_t;

  typedef struct packed {
    logic [11:0] ex;
    logic [2:0]  mem;
    logic [2:0]  wb;
  } exp_t;

  instr_t itab[$];
  exp_t   hist [0:4095];
  int     n;
  int     mult_edge;
  int     n_assert = 0;
  int     n_fail = 0;

  function automatic instr_t mk(logic [5:0] op, logic [5:0] fn, cat_e c, logic [3:0] alu);
    instr_t i;
    i.op = op; i.fn = fn; i.cat = c; i.alu = alu;
    return i;
  endfunction

  // Expected controls derived from instruction class semantics.
  function automatic exp_t expect_for(instr_t i);
    exp_t e;
    logic alu_src, se, rd, sm, ms, mw, mr, rw, m2r;
    logic [1:0] os;
    alu_src = i.cat inside {C_IALU_S, C_IALU_Z, C_LOAD, C_STORE};
    se      = i.cat inside {C_IALU_S, C_LOAD, C_STORE};
    rd      = i.cat inside {C_RALU, C_MFHI, C_MFLO};
    sm      = i.cat inside {C_MULT, C_MULTU};
    ms      = (i.cat == C_MULT);
    os      = (i.cat == C_MFHI) ? 2'b01 : (i.cat == C_MFLO) ? 2'b10 : 2'b00;
    mw      = (i.cat == C_STORE);
    mr      = (i.cat == C_LOAD);
    rw      = i.cat inside {C_RALU, C_IALU_S, C_IALU_Z, C_LOAD, C_MFHI, C_MFLO};
    m2r     = (i.cat == C_LOAD);
    e.ex    = {alu_src, i.alu, se, rd, sm, ms, os, 1'b1};
    e.mem   = {mw, mr, 1'b1};
    e.wb    = {rw, m2r, 1'b1};
    return e;
  endfunction

  function automatic exp_t h(int k);
    return (k < 1) ? exp_t'('0) : hist[k];
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"}, 16'(id_stall), 16'h0);
    check({tag, "_pcsrc"}, 16'(pc_source), 16'h0);
    check({tag, "_flush"}, 16'(if_flush), 16'h0);
    check({tag, "_ex"},    16'(ex_bundle), 16'h0);
    check({tag, "_mem"},   16'(mem_bundle), 16'h0);
    check({tag, "_wb"},    16'(wb_bundle), 16'h0);
    check({tag, "_busy"},  16'(mult_busy), 16'h0);
  endtask

  task automatic model_reset();
    n = 0;
    mult_edge = -1000;
  endtask

  // One clock: drive ID, check combinational outputs, clock, check stages.
  task automatic step(input bit v, input instr_t ins, input logic eq, output bit acc);
    bit busy, stall;
    logic [1:0] pcs;
    exp_t e;
    id_valid = v; op_code = ins.op; control_unit_funct = ins.fn; eq_ne = eq;
    #1;
    busy  = (n < mult_edge + L);
    stall = v && (ins.cat inside {C_MFHI, C_MFLO, C_MULT, C_MULTU}) && busy;
    pcs   = 2'b00;
    if (v && !stall) begin
      if (ins.cat == C_JMP) pcs = 2'b01;
      else if ((ins.cat == C_BEQ && eq) || (ins.cat == C_BNE && !eq)) pcs = 2'b10;
    end
    check("id_stall", 16'(id_stall), 16'(stall));
    check("pc_source", 16'(pc_source), 16'(pcs));
    check("if_flush", 16'(if_flush), 16'(pcs != 2'b00));
    acc = v && !stall;
    e = acc ? expect_for(ins) : exp_t'('0);
    @(posedge clk);
    #1;
    n++;
    hist[n] = e;
    if (acc && ins.cat inside {C_MULT, C_MULTU}) mult_edge = n;
    check("ex_bundle", 16'(ex_bundle), 16'(h(n).ex));
    check("mem_bundle", 16'(mem_bundle), 16'(h(n-1).mem));
    check("wb_bundle", 16'(wb_bundle), 16'(h(n-NWB).wb));
    check("mult_busy", 16'(mult_busy), 16'(n < mult_edge + L));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    instr_t i_add, i_mult, i_mflo, i_mfhi, i_beq, i_bne, i_j, i_bad, i_idle, cur;
    bit acc, cur_pending;
    int stalls, busy_seen, t0, k;

    itab.push_back(mk(6'b000000, 6'b000000, C_NOP,    4'b0000));
    itab.push_back(mk(6'b000000, 6'b100000, C_RALU,   4'b0100));
    itab.push_back(mk(6'b000000, 6'b100001, C_RALU,   4'b0101));
    itab.push_back(mk(6'b000000, 6'b100010, C_RALU,   4'b0110));
    itab.push_back(mk(6'b000000, 6'b100011, C_RALU,   4'b0111));
    itab.push_back(mk(6'b000000, 6'b100100, C_RALU,   4'b1000));
    itab.push_back(mk(6'b000000, 6'b100101, C_RALU,   4'b1001));
    itab.push_back(mk(6'b000000, 6'b100110, C_RALU,   4'b1010));
    itab.push_back(mk(6'b000000, 6'b100111, C_RALU,   4'b1011));
    itab.push_back(mk(6'b000000, 6'b101010, C_RALU,   4'b1100));
    itab.push_back(mk(6'b000000, 6'b101011, C_RALU,   4'b1101));
    itab.push_back(mk(6'b000000, 6'b010000, C_MFHI,   4'b0000));
    itab.push_back(mk(6'b000000, 6'b010010, C_MFLO,   4'b0000));
    itab.push_back(mk(6'b000000, 6'b011000, C_MULT,   4'b0000));
    itab.push_back(mk(6'b000000, 6'b011001, C_MULTU,  4'b0000));
    itab.push_back(mk(6'b000010, 6'b000000, C_JMP,    4'b0000));
    itab.push_back(mk(6'b000100, 6'b000000, C_BEQ,    4'b0000));
    itab.push_back(mk(6'b000101, 6'b000000, C_BNE,    4'b0000));
    itab.push_back(mk(6'b001000, 6'b000000, C_IALU_S, 4'b0100));
    itab.push_back(mk(6'b001001, 6'b000000, C_IALU_S, 4'b0101));
    itab.push_back(mk(6'b001010, 6'b000000, C_IALU_S, 4'b1100));
    itab.push_back(mk(6'b001011, 6'b000000, C_IALU_S, 4'b1101));
    itab.push_back(mk(6'b001100, 6'b000000, C_IALU_Z, 4'b1000));
    itab.push_back(mk(6'b001101, 6'b000000, C_IALU_Z, 4'b1001));
    itab.push_back(mk(6'b001110, 6'b000000, C_IALU_Z, 4'b1010));
    itab.push_back(mk(6'b001111, 6'b000000, C_IALU_Z, 4'b0001));
    itab.push_back(mk(6'b100011, 6'b000000, C_LOAD,   4'b0100));
    itab.push_back(mk(6'b101011, 6'b000000, C_STORE,  4'b0100));
    itab.push_back(mk(6'b111111, 6'b000000, C_NOP,    4'b0000));
    itab.push_back(mk(6'b000001, 6'b010101, C_NOP,    4'b0000));
    itab.push_back(mk(6'b000000, 6'b111111, C_NOP,    4'b0000));
    itab.push_back(mk(6'b000000, 6'b000001, C_NOP,    4'b0000));

    i_add  = itab[1];
    i_mfhi = itab[11];
    i_mflo = itab[12];
    i_mult = itab[13];
    i_j    = itab[15];
    i_beq  = itab[16];
    i_bne  = itab[17];
    i_bad  = itab[28];
    i_idle = itab[0];

    // Reset state, with a jump presented to prove outputs stay quiet.
    model_reset();
    id_valid = 1'b1; op_code = 6'b000010;
    repeat (2) @(posedge clk);
    #2;
    check_all_zero("reset");
    id_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // ADD: EX ALU code after one cycle, reg_write at WB NWB cycles later.
    step(1, i_add, 0, acc);
    check("add_alu_func", 16'(ex_bundle[10:7]), 16'b0100);
    for (int i = 0; i < NWB; i++) step(0, i_idle, 0, acc);
    check("add_wb_reg_write", 16'(wb_bundle[2]), 16'h1);

    // MULT followed by MFLO: count stall cycles and busy cycles.
    step(1, i_mult, 0, acc);
    t0 = n;
    busy_seen = mult_busy ? 1 : 0;
    stalls = 0;
    acc = 0;
    for (int i = 0; i < 10 && !acc; i++) begin
      step(1, i_mflo, 0, acc);
      if (!acc) begin
        stalls++;
        if (mult_busy) busy_seen++;
      end
    end
    check("mflo_stall_cycles", 16'(stalls), 16'(L));
    check("mult_busy_cycles", 16'(busy_seen), 16'(L));
    check("mflo_ex_cycle", 16'(n - t0 + 1), 16'(L + 2));
    check("mflo_ex_outsel", 16'(ex_bundle[2:1]), 16'b10);

    // Branch resolution.
    step(1, i_beq, 1, acc);
    step(1, i_beq, 0, acc);
    step(1, i_bne, 1, acc);
    step(1, i_bne, 0, acc);

    // Jump next to a stalled MFHI: jump redirects once, MFHI then waits.
    step(1, i_mult, 0, acc);
    step(1, i_j, 0, acc);
    acc = 0;
    for (int i = 0; i < 10 && !acc; i++) step(1, i_mfhi, 0, acc);
    step(0, i_j, 0, acc);

    // Reset two cycles into a multiply.
    step(1, i_mult, 0, acc);
    step(0, i_idle, 0, acc);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid_mult");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, i_mfhi, 0, acc);
    check("mfhi_after_reset_accepted", 16'(acc), 16'h1);

    // Unused opcode: NOOP with valid, no writes downstream.
    step(1, i_bad, 0, acc);
    check("bad_op_ex", 16'(ex_bundle), 16'h001);
    for (int i = 0; i < NWB; i++) step(0, i_idle, 0, acc);
    check("bad_op_wb", 16'(wb_bundle), 16'b001);

    // Random stream; stalled instructions are held in ID until accepted.
    cur = i_idle;
    cur_pending = 0;
    for (int i = 0; i < 600; i++) begin
      bit v;
      if (cur_pending) begin
        v = 1;
      end else begin
        k = $urandom_range(0, itab.size() - 1);
        cur = itab[k];
        if (cur.op != 6'b000000) cur.fn = 6'($urandom);
        v = ($urandom_range(0, 9) < 8);
      end
      step(v, cur, 1'($urandom), acc);
      cur_pending = v && !acc;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
